// File: rtl/ndro_bank.sv
// N-channel cycle-based NDRO/DRO storage bank with hold-window checks and startup blanking.
// Optional macro NDRO_BANK_VIOL_COUNT_EN adds the 16-bit saturating viol_count output.
module ndro_bank #(
  parameter int N              = 4,
  parameter int MODE           = 0,
  parameter int HOLD_CYCLES    = 3,
  parameter int STARTUP_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] set,
  input  logic [N-1:0] clr,
  input  logic [N-1:0] rd,
  input  logic         viol_clr,
  output logic [N-1:0] out,
  output logic [N-1:0] state,
  output logic [N-1:0] viol_sc,
  output logic [N-1:0] viol_cr,
  output logic [N-1:0] coll
`ifdef NDRO_BANK_VIOL_COUNT_EN
  ,
  output logic [15:0]  viol_count
`endif
);

  localparam logic [7:0] HOLD    = 8'(HOLD_CYCLES);
  localparam logic [7:0] STARTUP = 8'(STARTUP_CYCLES);

  logic [N-1:0] set_q, clr_q, rd_q;
  logic [N-1:0] out_q, out_d, state_q, state_d;
  logic [N-1:0] viol_sc_q, viol_sc_d, viol_cr_q, viol_cr_d, coll_q, coll_d;
  logic [N-1:0] rd_armed_q, rd_armed_d;
  logic [7:0]   since_clr_q [N];
  logic [7:0]   since_clr_d [N];
  logic [7:0]   since_rd_q  [N];
  logic [7:0]   since_rd_d  [N];
  logic [7:0]   blank_q, blank_d;

  logic [N-1:0] set_p, clr_p, rd_p, hit_s, sc_ev, cr_ev, coll_ev;
  logic         active_s;

`ifdef NDRO_BANK_VIOL_COUNT_EN
  logic [15:0] viol_count_q, viol_count_d, count_base_s;
  logic [6:0]  viol_inc_s;
  logic [16:0] count_sum_s;
`endif

  always_comb begin
    set_p    = set ^ set_q;
    clr_p    = clr ^ clr_q;
    rd_p     = rd ^ rd_q;
    active_s = (blank_q == 8'd0);
    if (active_s) blank_d = 8'd0;
    else          blank_d = blank_q - 8'd1;

    out_d      = out_q;
    state_d    = state_q;
    rd_armed_d = rd_armed_q;
    hit_s      = {N{1'b0}};
    sc_ev      = {N{1'b0}};
    cr_ev      = {N{1'b0}};
    coll_ev    = {N{1'b0}};

    for (int i = 0; i < N; i++) begin
      since_clr_d[i] = since_clr_q[i];
      since_rd_d[i]  = since_rd_q[i];
      if (active_s) begin
        hit_s[i] = rd_p[i] & state_q[i];
        out_d[i] = out_q[i] ^ hit_s[i];

        // A DRO read clears the bit unless a same-cycle set wins
        if (set_p[i] & clr_p[i])          state_d[i] = state_q[i];
        else if (clr_p[i])                state_d[i] = 1'b0;
        else if (set_p[i])                state_d[i] = 1'b1;
        else if ((MODE == 1) && hit_s[i]) state_d[i] = 1'b0;
        else                              state_d[i] = state_q[i];

        coll_ev[i] = set_p[i] & clr_p[i];
        sc_ev[i]   = set_p[i] & ((since_clr_q[i] < HOLD) | clr_p[i]);
        cr_ev[i]   = clr_p[i] & ((rd_armed_q[i] & (since_rd_q[i] < HOLD)) | hit_s[i]);

        if (clr_p[i])                   since_clr_d[i] = 8'd0;
        else if (since_clr_q[i] < HOLD) since_clr_d[i] = since_clr_q[i] + 8'd1;
        else                            since_clr_d[i] = since_clr_q[i];

        if (rd_p[i]) begin
          since_rd_d[i] = 8'd0;
          rd_armed_d[i] = state_q[i];
        end else if (since_rd_q[i] < HOLD) begin
          since_rd_d[i] = since_rd_q[i] + 8'd1;
        end else begin
          since_rd_d[i] = since_rd_q[i];
        end
      end else begin
        hit_s[i] = 1'b0;
      end
    end

    // New violations override a same-edge viol_clr
    if (viol_clr) begin
      viol_sc_d = sc_ev;
      viol_cr_d = cr_ev;
    end else begin
      viol_sc_d = viol_sc_q | sc_ev;
      viol_cr_d = viol_cr_q | cr_ev;
    end
    coll_d = coll_q | coll_ev;

`ifdef NDRO_BANK_VIOL_COUNT_EN
    viol_inc_s = 7'd0;
    for (int i = 0; i < N; i++) begin
      viol_inc_s = viol_inc_s + 7'(sc_ev[i]) + 7'(cr_ev[i]);
    end
    if (viol_clr) count_base_s = 16'd0;
    else          count_base_s = viol_count_q;
    count_sum_s = {1'b0, count_base_s} + 17'(viol_inc_s);
    if (count_sum_s[16]) viol_count_d = 16'hFFFF;
    else                 viol_count_d = count_sum_s[15:0];
`endif
  end

  always_ff @(posedge clk) begin
    set_q <= set;
    clr_q <= clr;
    rd_q  <= rd;
    if (reset) begin
      out_q      <= {N{1'b0}};
      state_q    <= {N{1'b0}};
      viol_sc_q  <= {N{1'b0}};
      viol_cr_q  <= {N{1'b0}};
      coll_q     <= {N{1'b0}};
      rd_armed_q <= {N{1'b0}};
      blank_q    <= STARTUP;
      for (int i = 0; i < N; i++) begin
        since_clr_q[i] <= HOLD;
        since_rd_q[i]  <= HOLD;
      end
`ifdef NDRO_BANK_VIOL_COUNT_EN
      viol_count_q <= 16'd0;
`endif
    end else begin
      out_q      <= out_d;
      state_q    <= state_d;
      viol_sc_q  <= viol_sc_d;
      viol_cr_q  <= viol_cr_d;
      coll_q     <= coll_d;
      rd_armed_q <= rd_armed_d;
      blank_q    <= blank_d;
      for (int i = 0; i < N; i++) begin
        since_clr_q[i] <= since_clr_d[i];
        since_rd_q[i]  <= since_rd_d[i];
      end
`ifdef NDRO_BANK_VIOL_COUNT_EN
      viol_count_q <= viol_count_d;
`endif
    end
  end

  assign out     = out_q;
  assign state   = state_q;
  assign viol_sc = viol_sc_q;
  assign viol_cr = viol_cr_q;
  assign coll    = coll_q;
`ifdef NDRO_BANK_VIOL_COUNT_EN
  assign viol_count = viol_count_q;
`endif

endmodule
